// File: rtl/wide_add_seq_if.sv
// Bundles the request/result handshake and the shared-adder operand/result
// path of wide_add_seq; the slave side is the sequencer itself.
interface wide_add_seq_if #(
    parameter int W = 32,
    parameter int N = 4
);
    // Request: start is taken on a rising edge only while the sequencer is
    // idle or showing done; busy marks the run, done is a one-cycle pulse
    // during which sum/carry_out are valid (they stay valid until the next
    // accepted start).
    logic             start;
    logic [N*W-1:0]   in_a;
    logic [N*W-1:0]   in_b;
    logic             busy;
    logic             done;
    logic [N*W-1:0]   sum;
    logic             carry_out;

    // Shared adder: combinational, add_out follows add_a/add_b in the same cycle.
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic [W:0]       add_out;

    modport master (
        output start, in_a, in_b, add_out,
        input  busy, done, sum, carry_out, add_a, add_b
    );

    modport slave (
        input  start, in_a, in_b, add_out,
        output busy, done, sum, carry_out, add_a, add_b
    );
endinterface

// File: rtl/wide_add_seq.sv
// N*W-bit adder built from one shared W-bit adder without carry-in: each chunk
// takes two passes (operand add, then carry add), walking LSB chunk first.
module wide_add_seq #(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              reset,
    wide_add_seq_if.slave     bus,
    output logic [1:0]        o_dbg_state
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [N*W-1:0]  r_op_a;
    logic [N*W-1:0]  r_op_b;
    logic [N*W-1:0]  r_sum;
    logic [IW-1:0]   r_idx;
    logic            r_ph;
    logic [W:0]      r_partial;
    logic            r_c;
    logic            r_carry_out;

    logic            w_accept;
    logic            w_last;
    logic            w_c_new;

    // Operand-pass carry and carry-pass carry cannot both be set, so OR is exact.
    assign w_c_new = r_partial[W] | bus.add_out[W];
    assign w_last  = r_ph && (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_accept   = bus.start;
                w_state_nx = bus.start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_ph        <= 1'b0;
            r_partial   <= '0;
            r_c         <= 1'b0;
            r_carry_out <= 1'b0;
        end else if (w_accept) begin
            r_op_a      <= bus.in_a;
            r_op_b      <= bus.in_b;
            r_sum       <= '0;
            r_idx       <= '0;
            r_ph        <= 1'b0;
            r_partial   <= '0;
            r_c         <= 1'b0;
            r_carry_out <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (!r_ph) begin
                r_partial <= bus.add_out;
                r_ph      <= 1'b1;
            end else begin
                r_sum[r_idx*W +: W] <= bus.add_out[W-1:0];
                r_c                 <= w_c_new;
                r_ph                <= 1'b0;
                if (r_idx == LAST_IDX) begin
                    r_carry_out <= w_c_new;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    // Adder operands are parked at zero whenever no chunk is being worked on.
    always_comb begin
        bus.add_a = '0;
        bus.add_b = '0;
        if (r_state == S_RUN) begin
            if (!r_ph) begin
                bus.add_a = r_op_a[r_idx*W +: W];
                bus.add_b = r_op_b[r_idx*W +: W];
            end else begin
                bus.add_a = r_partial[W-1:0];
                bus.add_b = {{(W-1){1'b0}}, r_c};
            end
        end
    end

    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry_out;
    assign o_dbg_state   = r_state;
endmodule
